// File: rtl/fp_mul_seq.sv
// Multi-cycle binary32 multiplier with flush-to-zero, shift-add mantissa datapath
// retiring BITS_PER_CYC multiplier bits per cycle, and valid/ready on both sides.
module fp_mul_seq #(
  parameter int BITS_PER_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  localparam int B = BITS_PER_CYC;
  localparam int K = 24 / BITS_PER_CYC;
  localparam int W = 24 + BITS_PER_CYC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RND  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        r_sign;
  logic [7:0]  r_ex;
  logic [7:0]  r_ey;
  logic [23:0] r_mx;
  logic [23:0] r_my;
  logic [47:0] r_acc;
  logic [4:0]  r_cnt;
  logic [2:0]  r_rmode;
  logic [31:0] r_z;
  logic        r_ovrf;
  logic        r_udrf;

  function automatic logic is_zero(input logic [31:0] op);
    is_zero = (op[30:23] == 8'h00);
  endfunction

  function automatic logic is_nan(input logic [31:0] op);
    is_nan = (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] op);
    is_inf = (op[30:23] == 8'hFF) && (op[22:0] == 23'd0);
  endfunction

  // Overflow saturates to infinity unless the rounding direction points back toward zero.
  function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sign);
    case (mode)
      3'b001:  ovf_to_inf = 1'b0;
      3'b010:  ovf_to_inf = sign;
      3'b011:  ovf_to_inf = ~sign;
      default: ovf_to_inf = 1'b1;
    endcase
  endfunction

  logic        w_accept;
  logic        w_sign_in;
  logic        w_special;
  logic [31:0] w_spec_z;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_sign_in = fp_X[31] ^ fp_Y[31];
  assign w_special = is_zero(fp_X) || is_zero(fp_Y) || is_nan(fp_X) || is_nan(fp_Y) ||
                     is_inf(fp_X) || is_inf(fp_Y);

  // Special-case result: NaN/invalid, infinity, or signed zero.
  always_comb begin
    w_spec_z = {w_sign_in, 31'd0};
    if (is_nan(fp_X) || is_nan(fp_Y) ||
        (is_zero(fp_X) && is_inf(fp_Y)) || (is_inf(fp_X) && is_zero(fp_Y))) begin
      w_spec_z = 32'h7FC0_0000;
    end else if (is_inf(fp_X) || is_inf(fp_Y)) begin
      w_spec_z = {w_sign_in, 31'h7F80_0000};
    end else begin
      w_spec_z = {w_sign_in, 31'd0};
    end
  end

  // One shift-add step: low B bits of mantX times mantY join the upper accumulator half.
  logic [W-1:0]  w_pp;
  logic [W:0]    w_hi_sum;
  logic [W+24:0] w_cat;
  logic [47:0]   w_acc_nxt;

  assign w_pp      = {{B{1'b0}}, r_my} * {{24{1'b0}}, r_mx[B-1:0]};
  assign w_hi_sum  = {{(B + 1){1'b0}}, r_acc[47:24]} + {1'b0, w_pp};
  assign w_cat     = {w_hi_sum, r_acc[23:0]};
  assign w_acc_nxt = w_cat[B +: 48];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_MUL;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (r_cnt == 5'(K - 1)) begin
          w_state_nxt = S_RND;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_RND: w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, then one multiplier digit per MUL cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign  <= 1'b0;
      r_ex    <= 8'd0;
      r_ey    <= 8'd0;
      r_mx    <= 24'd0;
      r_my    <= 24'd0;
      r_acc   <= 48'd0;
      r_cnt   <= 5'd0;
      r_rmode <= 3'd0;
    end else if (w_accept) begin
      r_sign  <= w_sign_in;
      r_ex    <= fp_X[30:23];
      r_ey    <= fp_Y[30:23];
      r_mx    <= {1'b1, fp_X[22:0]};
      r_my    <= {1'b1, fp_Y[22:0]};
      r_acc   <= 48'd0;
      r_cnt   <= 5'd0;
      r_rmode <= r_mode;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nxt;
      r_mx  <= r_mx >> B;
      r_cnt <= r_cnt + 5'd1;
    end
  end

  logic signed [9:0] w_e0;
  logic signed [9:0] w_e1;
  logic signed [9:0] w_e2;
  logic [22:0]       w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [23:0]       w_mant_sum;
  logic [22:0]       w_mant_r;
  logic [31:0]       w_rnd_z;
  logic              w_rnd_ovrf;
  logic              w_rnd_udrf;

  assign w_e0 = $signed({2'b00, r_ex}) + $signed({2'b00, r_ey}) - 10'sd127;

  // Normalise, round and classify the finished product.
  always_comb begin
    w_mant     = 23'd0;
    w_guard    = 1'b0;
    w_sticky   = 1'b0;
    w_e1       = w_e0;
    w_inc      = 1'b0;
    w_mant_r   = 23'd0;
    w_e2       = w_e0;
    w_rnd_z    = 32'd0;
    w_rnd_ovrf = 1'b0;
    w_rnd_udrf = 1'b0;
    if (r_acc[47]) begin
      w_mant   = r_acc[46:24];
      w_guard  = r_acc[23];
      w_sticky = |r_acc[22:0];
      w_e1     = w_e0 + 10'sd1;
    end else begin
      w_mant   = r_acc[45:23];
      w_guard  = r_acc[22];
      w_sticky = |r_acc[21:0];
      w_e1     = w_e0;
    end
    case (r_rmode)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & (w_guard | w_sticky);
      3'b011:  w_inc = ~r_sign & (w_guard | w_sticky);
      3'b100:  w_inc = w_guard;
      default: w_inc = w_guard & (w_sticky | w_mant[0]);
    endcase
    w_mant_sum = {1'b0, w_mant} + {23'd0, w_inc};
    if (w_mant_sum[23]) begin
      w_mant_r = 23'd0;
      w_e2     = w_e1 + 10'sd1;
    end else begin
      w_mant_r = w_mant_sum[22:0];
      w_e2     = w_e1;
    end
    if (w_e1 <= 10'sd0) begin
      w_rnd_z    = {r_sign, 31'd0};
      w_rnd_udrf = 1'b1;
    end else if (w_e2 >= 10'sd255) begin
      w_rnd_ovrf = 1'b1;
      if (ovf_to_inf(r_rmode, r_sign)) begin
        w_rnd_z = {r_sign, 31'h7F80_0000};
      end else begin
        w_rnd_z = {r_sign, 31'h7F7F_FFFF};
      end
    end else begin
      w_rnd_z = {r_sign, w_e2[7:0], w_mant_r};
    end
  end

  // Result registers: loaded at special-case accept or at the end of RND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z    <= 32'd0;
      r_ovrf <= 1'b0;
      r_udrf <= 1'b0;
    end else if (w_accept && w_special) begin
      r_z    <= w_spec_z;
      r_ovrf <= 1'b0;
      r_udrf <= 1'b0;
    end else if (r_state == S_RND) begin
      r_z    <= w_rnd_z;
      r_ovrf <= w_rnd_ovrf;
      r_udrf <= w_rnd_udrf;
    end
  end

  assign fp_Z = r_z;
  assign ovrf = r_ovrf;
  assign udrf = r_udrf;

endmodule
